pipe_stage_elastic: RTL and testbench

- Parametrised successor to the fixed-field pipeline registers between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed payload: DATA_W data bits plus CTRL_W control bits, where the control bits are RegWrite/MemWrite-class enables.
- Uses a valid/ready elastic handshake and a 2-entry skid buffer, so throughput is full with no combinational ready path upstream.
- Provides external stall and flush. Flush inserts a bubble using a configurable kill value.

---
 rtl/pipe_stage_elastic.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer, stall and flush; 1-cycle latency.
// in_ready is a flop (~skid_valid); stall freezes the stage; flush beats stall. Option: PIPE_STAGE_PERF_EN.
module pipe_stage_elastic #(
    parameter int                 DATA_W           = 32,
    parameter int                 CTRL_W           = 16,
    parameter logic [CTRL_W-1:0]  CTRL_KILL        = {CTRL_W{1'b0}},
    parameter bit                 FLUSH_KEEPS_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              acc, emit;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    assign acc  = in_valid & in_ready & ~stall;
    assign emit = main_valid_q & out_ready & ~stall;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_ctrl_d  = CTRL_KILL;
            skid_ctrl_d  = CTRL_KILL;
            if (!FLUSH_KEEPS_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (acc) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                        main_ctrl_d  = in_ctrl;
                    end
                end
                2'b10: begin
                    if (acc && emit) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (acc) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                        skid_ctrl_d  = in_ctrl;
                    end else if (emit) begin
                        // Draining to empty re-kills ctrl so downstream can gate on out_ctrl alone.
                        main_valid_d = 1'b0;
                        main_ctrl_d  = CTRL_KILL;
                    end
                end
                2'b11: begin
                    if (emit) begin
                        main_data_d  = skid_data_q;
                        main_ctrl_d  = skid_ctrl_q;
                        skid_valid_d = 1'b0;
                        skid_ctrl_d  = CTRL_KILL;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            main_ctrl_q  <= CTRL_KILL;
            skid_ctrl_q  <= CTRL_KILL;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall && main_valid_q && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (!main_valid_q && out_ready && !(&bubble_cnt_q))
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_pipe_stage_elastic;

    localparam int          DW   = 32;
    localparam int          CW   = 16;
    localparam logic [15:0] KILL = 16'h5A00;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, stall, flush;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt, bubble_cnt;
    logic [31:0]   m_stall, m_bubble;
`endif

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .DATA_W(DW), .CTRL_W(CW), .CTRL_KILL(KILL), .FLUSH_KEEPS_DATA(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall(stall), .flush(flush), .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t mq[$];
    int   errors = 0;
    int   checks = 0;
    bit   cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the stage is a FIFO of depth 2; flush empties it, stall freezes it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
`ifdef PIPE_STAGE_PERF_EN
            m_stall  = 0;
            m_bubble = 0;
`endif
        end else begin
            int sz;
            sz = mq.size();
`ifdef PIPE_STAGE_PERF_EN
            if (stall && sz > 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (sz == 0 && out_ready && m_bubble != 32'hFFFF_FFFF) m_bubble++;
`endif
            if (flush) mq.delete();
            else if (!stall) begin
                if (sz > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && sz < 2) mq.push_back('{d: in_data, c: in_ctrl});
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("occupancy", 64'(occupancy), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            chk("out_ctrl", 64'(out_ctrl), (mq.size() > 0) ? 64'(mq[0].c) : 64'(KILL));
            if (mq.size() > 0) chk("out_data", 64'(out_data), 64'(mq[0].d));
`ifdef PIPE_STAGE_PERF_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
        end
    end

    // Drive one cycle of inputs, then return at the following negedge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic [15:0] c,
                       input logic ordy, input logic st, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        @(negedge clk);
    endtask

    initial begin
        int nvalid, nrdy_low;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'h5A00);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Streaming
        nvalid = 0; nrdy_low = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 32'(i), 16'(i + 100), 1'b1, 1'b0, 1'b0);
            if (out_valid) nvalid++;
            if (!in_ready) nrdy_low++;
            chk("stream_data", 64'(out_data), 64'(i));
        end
        chk("stream_valid_cycles", 64'(nvalid), 64'd16);
        chk("stream_in_ready_low", 64'(nrdy_low), 64'd0);
        cyc(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Backpressure
        cyc(1'b1, 32'hAAAA_0001, 16'h0011, 1'b0, 1'b0, 1'b0);
        chk("bp_occ1", 64'(occupancy), 64'd1);
        cyc(1'b1, 32'hBBBB_0002, 16'h0022, 1'b0, 1'b0, 1'b0);
        chk("bp_occ2", 64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        chk("bp_head_A", 64'(out_data), 64'hAAAA_0001);
        cyc(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        chk("bp_next_B", 64'(out_data), 64'hBBBB_0002);
        chk("bp_next_B_ctrl", 64'(out_ctrl), 64'h0022);
        chk("bp_occ_after", 64'(occupancy), 64'd1);
        cyc(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);

        // Flush while FULL, with a valid input present that must be discarded
        cyc(1'b1, 32'h1234_5678, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h9ABC_DEF0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0BAD_F00D, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_ctrl", 64'(out_ctrl), 64'h5A00);
        chk("fl_out_data", 64'(out_data), 64'd0);
        chk("fl_occupancy", 64'(occupancy), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);

        // Stall holds everything, then flush beats stall
        cyc(1'b1, 32'hC0DE_0001, 16'h0033, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'(i), 16'h0044, 1'b1, 1'b1, 1'b0);
            chk("st_hold_data", 64'(out_data), 64'hC0DE_0001);
            chk("st_hold_occ", 64'(occupancy), 64'd1);
        end
        cyc(1'b1, 32'h7, 16'h0044, 1'b1, 1'b1, 1'b1);
        chk("st_flush_occ", 64'(occupancy), 64'd0);
        chk("st_flush_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges while FULL
        cyc(1'b1, 32'h1111_1111, 16'h0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h2222_2222, 16'h0002, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_occupancy", 64'(occupancy), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h3333_3333, 16'h0003, 1'b1, 1'b0, 1'b0);
        chk("ar_first_valid", 64'(out_valid), 64'd1);
        chk("ar_first_data", 64'(out_data), 64'h3333_3333);
        cyc(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
        rst_n = 1'b0;
        cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 32'h4444_4444, 16'h0004, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        chk("perf_stall_cnt", 64'(stall_cnt), 64'd5);
        chk("perf_bubble_cnt", 64'(bubble_cnt), 64'd3);
`endif

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 9) < 7), $urandom, 16'($urandom),
                1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 39) == 0));
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
